// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : 8N1 UART transmitter fed by a small byte FIFO; frames are sent
//            back-to-back with one idle clock between them. Defining
//            UART_TX_PARITY_EN adds an even-parity bit (8E1 framing).
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int baud_rate    = 19200,
    parameter int sys_clk_freq = 100000000,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       transmit,
    input  logic [7:0] tx_byte,
    output logic       tx,
    output logic       is_transmitting,
    output logic       fifo_full,
    output logic       fifo_empty,
    output logic       overflow
);

    localparam int c_CLKS_PER_BIT = sys_clk_freq / baud_rate;
    localparam int c_BAUD_W       = (c_CLKS_PER_BIT > 1) ? $clog2(c_CLKS_PER_BIT) : 1;
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(c_CLKS_PER_BIT - 1);
    localparam int c_PTR_W        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W        = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;
`endif

    state_t               r_state;
    state_t               w_state_next;

    logic [7:0]           r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;

    logic [7:0]           r_data;
    logic [2:0]           r_bit_idx;
    logic [c_BAUD_W-1:0]  r_baud_cnt;
    logic                 r_tx;
    logic                 r_busy;
    logic                 r_overflow;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_drop;
    logic                 w_pop;
    logic                 w_baud_done;
    logic                 w_tx_next;
    logic                 w_busy_next;

    // Fullness is judged on the registered count, before any same-cycle pop.
    assign w_full      = (r_count == c_FULL_CNT);
    assign w_empty     = (r_count == '0);
    assign w_push      = transmit & ~w_full;
    assign w_drop      = transmit & w_full;
    assign w_baud_done = (r_baud_cnt == c_BAUD_LAST);

    assign tx              = r_tx;
    assign is_transmitting = r_busy;
    assign fifo_full       = w_full;
    assign fifo_empty      = w_empty;
    assign overflow        = r_overflow;

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_byte;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_drop;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_data     <= '0;
            r_bit_idx  <= '0;
            r_baud_cnt <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_tx    <= w_tx_next;
            r_busy  <= w_busy_next;
            if (w_pop) begin
                r_data <= r_mem[r_rd_ptr];
            end
            if ((r_state == S_IDLE) || w_baud_done) begin
                r_baud_cnt <= '0;
            end else begin
                r_baud_cnt <= r_baud_cnt + c_BAUD_W'(1);
            end
            if (r_state != S_DATA) begin
                r_bit_idx <= '0;
            end else if (w_baud_done) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
        end
    end

    // Line level is decided from the current state and registered, so tx
    // trails the state by one clock and never glitches.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_tx_next    = 1'b1;
        w_busy_next  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                w_tx_next   = 1'b0;
                w_busy_next = 1'b1;
                if (w_baud_done) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                w_tx_next   = r_data[r_bit_idx];
                w_busy_next = 1'b1;
                if (w_baud_done && (r_bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    w_state_next = S_PARITY;
`else
                    w_state_next = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                w_tx_next   = ^r_data;
                w_busy_next = 1'b1;
                if (w_baud_done) begin
                    w_state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                w_tx_next   = 1'b1;
                w_busy_next = 1'b1;
                if (w_baud_done) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Brief    : Scoreboard bench for uart_tx_fifo (16 clocks per bit); a
//            timing-level model predicts acceptance, pop time and frame bits.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int c_SYS   = 160;
    localparam int c_BAUD  = 10;
    localparam int c_CPB   = c_SYS / c_BAUD;
    localparam int c_DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int c_FRAME_BITS = 11;
`else
    localparam int c_FRAME_BITS = 10;
`endif
    localparam int c_FRAME_CLKS = c_FRAME_BITS * c_CPB;
    localparam int c_PERIOD     = c_FRAME_CLKS + 1;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       transmit = 1'b0;
    logic [7:0] tx_byte  = 8'h00;
    logic       tx;
    logic       is_transmitting;
    logic       fifo_full;
    logic       fifo_empty;
    logic       overflow;

    uart_tx_fifo #(
        .baud_rate    (c_BAUD),
        .sys_clk_freq (c_SYS),
        .FIFO_DEPTH   (c_DEPTH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .transmit        (transmit),
        .tx_byte         (tx_byte),
        .tx              (tx),
        .is_transmitting (is_transmitting),
        .fifo_full       (fifo_full),
        .fifo_empty      (fifo_empty),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    // cyc == number of rising edges seen so far; edge N is the N-th posedge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         start;
    } exp_t;

    exp_t exp_q[$];
    int   pend[$];
    int   ov_q[$];
    int   last_pop    = -100000;
    int   checks      = 0;
    int   failures    = 0;
    int   rst_epoch   = 0;
    int   frames_seen = 0;
    bit   mon_busy    = 1'b0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, req, cyc);
        end
    endfunction

    function automatic logic [10:0] frame_bits(input logic [7:0] b);
        logic [10:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
`ifdef UART_TX_PARITY_EN
        f[9]   = ^b;
`endif
        return f;
    endfunction

    // Model: bytes queued at edge n are those whose pop edge is >= n. A new
    // byte pops one edge after its push, or one frame period after the
    // previous pop, whichever is later; tx falls one edge after the pop.
    function automatic void model_push(input logic [7:0] b, input int n);
        int p;
        while (pend.size() > 0 && pend[0] < n) void'(pend.pop_front());
        if (pend.size() < c_DEPTH) begin
            p = (n + 1 > last_pop + c_PERIOD) ? n + 1 : last_pop + c_PERIOD;
            pend.push_back(p);
            last_pop = p;
            exp_q.push_back('{data: b, start: p + 1});
        end else begin
            ov_q.push_back(n);
        end
    endfunction

    function automatic int model_count_after(input int e);
        int c;
        c = 0;
        foreach (pend[i]) if (pend[i] > e) c++;
        return c;
    endfunction

    task automatic push(input logic [7:0] b);
        int n;
        int c;
        n = cyc + 1;
        model_push(b, n);
        transmit = 1'b1;
        tx_byte  = b;
        @(negedge clk);
        transmit = 1'b0;
        c = model_count_after(n);
        check("fifo_flags", 32'({fifo_full, fifo_empty}),
              32'({(c == c_DEPTH), (c == 0)}));
    endtask

    task automatic wait_drain();
        int budget;
        bit done;
        budget = ((last_pop > cyc) ? (last_pop - cyc) : 0) + c_PERIOD + 50;
        done   = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !mon_busy && (cyc > last_pop + c_PERIOD);
        end
        check("drain_within_budget", 32'(done), 32'd1);
    endtask

    task automatic clear_model();
        exp_q.delete();
        pend.delete();
        ov_q.delete();
        last_pop = -100000;
    endtask

    // Frame monitor: decodes each frame at bit centres and scores it.
    initial begin : frame_mon
        logic        prev_tx;
        logic        prev_its;
        logic [10:0] got;
        exp_t        e;
        int          s;
        int          ep;
        bit          have;
        bit          aborted;
        bit          its_ok;
        prev_tx  = 1'b1;
        prev_its = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && prev_tx && !tx) begin
                s        = cyc;
                ep       = rst_epoch;
                mon_busy = 1'b1;
                aborted  = 1'b0;
                its_ok   = 1'b1;
                got      = '1;
                check("its_low_before_frame", 32'(prev_its), 32'd0);
                have = (exp_q.size() > 0);
                check("frame_expected", 32'(have), 32'd1);
                if (have) begin
                    e = exp_q.pop_front();
                    check("frame_start_cycle", 32'(s), 32'(e.start));
                end
                for (int k = 0; k < c_FRAME_BITS && !aborted; k++) begin
                    while (cyc < s + k * c_CPB + c_CPB / 2 && rst_epoch == ep) @(negedge clk);
                    if (rst_epoch != ep || !rst_n) begin
                        aborted = 1'b1;
                    end else begin
                        got[k] = tx;
                        if (is_transmitting !== 1'b1) its_ok = 1'b0;
                    end
                end
                if (!aborted) begin
                    while (cyc < s + c_FRAME_CLKS - 1 && rst_epoch == ep) @(negedge clk);
                    if (rst_epoch != ep) aborted = 1'b1;
                    else check("its_high_whole_frame", 32'(its_ok & is_transmitting), 32'd1);
                end
                if (!aborted) begin
                    while (cyc < s + c_FRAME_CLKS && rst_epoch == ep) @(negedge clk);
                    if (rst_epoch != ep) aborted = 1'b1;
                    else check("frame_end_its_tx", 32'({is_transmitting, tx}), 32'b01);
                end
                if (!aborted) begin
                    frames_seen++;
                    if (have) check("frame_bits", 32'(got), 32'(frame_bits(e.data)));
                end
                mon_busy = 1'b0;
            end
            prev_tx  = tx;
            prev_its = is_transmitting;
        end
    end

    // Overflow monitor: every pulse must match a predicted drop edge.
    initial begin : ov_mon
        bit exp_ov;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                exp_ov = 1'b0;
                if (ov_q.size() > 0) begin
                    if (ov_q[0] == cyc) exp_ov = 1'b1;
                end
                if (overflow || exp_ov) begin
                    check("overflow_pulse", 32'(overflow), 32'(exp_ov));
                    if (exp_ov) void'(ov_q.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit         low_seen;
        int         s0;
        int         frames0;
        int         gap;
        logic [7:0] rb;
        logic [7:0] mid_byte;

        rst_n    = 1'b0;
        transmit = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_outputs", 32'({tx, is_transmitting, fifo_full, fifo_empty, overflow}),
              32'b10010);
        rst_n = 1'b1;
        low_seen = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1) low_seen = 1'b1;
        end
        check("idle_tx_high_100", 32'(low_seen), 32'd0);
        check("idle_fifo_empty", 32'(fifo_empty), 32'd1);

        // Single byte.
        push(8'hA5);
        wait_drain();

        // Burst of five while a frame is in flight: the fifth is dropped.
        push(8'h99);
        repeat (20) @(negedge clk);
        push(8'h01);
        push(8'h02);
        push(8'h03);
        push(8'h04);
        push(8'h05);
        wait_drain();

        // Push landing on the pop edge of a lone queued byte.
        push(8'hC3);
        push(8'h3C);
        wait_drain();

        // Parity-sensitive bytes (odd and even number of ones).
        push(8'h07);
        wait_drain();
        push(8'h03);
        wait_drain();

        // Randomized traffic mixing bursts and long gaps.
        for (int i = 0; i < 40; i++) begin
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 200) : $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
            rb = 8'($urandom);
            push(rb);
        end
        wait_drain();

        // Reset during data bit 3 with two bytes still queued.
        mid_byte = 8'h52;
        push(mid_byte);
        s0 = last_pop + 1;
        push(8'h11);
        push(8'h22);
        while (cyc < s0 + 4 * c_CPB + 6) @(negedge clk);
        check("tx_data_bit3_before_reset", 32'(tx), 32'(mid_byte[3]));
        #2;
        rst_n = 1'b0;
        rst_epoch++;
        clear_model();
        #1;
        check("async_reset_outputs", 32'({tx, is_transmitting, fifo_full, fifo_empty}),
              32'b1001);
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        frames0 = frames_seen;
        low_seen = 1'b0;
        repeat (400) begin
            @(negedge clk);
            if (tx !== 1'b1) low_seen = 1'b1;
        end
        check("no_frame_after_reset", 32'(low_seen), 32'd0);
        check("frames_after_reset", 32'(frames_seen), 32'(frames0));
        check("empty_after_reset", 32'(fifo_empty), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
